// File: rtl/seq_det_pkg.sv
// Shared constants for the serial-detector scheduler: FSM encoding and the
// pattern recognised by the external detector.
package seq_det_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = S_IDLE,
        ST_CLEAR = S_CLEAR,
        ST_SHIFT = S_SHIFT,
        ST_DONE  = S_DONE
    } state_e;

    localparam logic [3:0] DET_PATTERN = 4'b1101;

endpackage

// File: rtl/seq_det_scheduler_if.sv
// Requester and response channels of the scheduler. The scheduler uses the
// slave view; requesters and the result consumer use the master view.
interface seq_det_scheduler_if #(
    parameter int NREQ = 4,
    parameter int W    = 8
);
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(W + 1);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              resp_valid;
    logic              resp_ready;
    logic [IDW-1:0]    resp_id;
    logic [CW-1:0]     resp_count;
    logic              resp_hit;

    modport master (
        output req_valid, req_data, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_count, resp_hit
    );

    modport slave (
        input  req_valid, req_data, resp_ready,
        output req_ready, resp_valid, resp_id, resp_count, resp_hit
    );

endinterface

// File: rtl/seq_det_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// the pointer, searching modulo NREQ. The pointer register lives in the parent.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    input  logic            en_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  idx_o
);

    localparam int SW = IDW + 1;

    logic [SW-1:0]  sum_s;
    logic [IDW-1:0] cand_s;
    logic           found_s;

    // Rotating priority search starting at the pointer
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        sum_s   = '0;
        cand_s  = '0;
        found_s = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            sum_s = {1'b0, ptr_i} + SW'(k);
            if (sum_s >= SW'(NREQ)) begin
                sum_s = sum_s - SW'(NREQ);
            end else begin
                sum_s = sum_s;
            end
            cand_s = sum_s[IDW-1:0];
            if (en_i && !found_s && req_i[cand_s]) begin
                gnt_o[cand_s] = 1'b1;
                idx_o         = cand_s;
                found_s       = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/seq_det_scheduler.sv
// Shares one external 1101 Mealy detector among NREQ word requesters: grants
// round-robin, clears the detector, shifts the word MSB-first, counts matches.
module seq_det_scheduler
    import seq_det_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    seq_det_scheduler_if.slave      sched,
    output logic                    det_rst,
    output logic                    det_din,
    input  logic                    det_y,
    output logic                    busy
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(W + 1);

    state_e         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [W-1:0]   shreg_q, shreg_d;
    logic [CW-1:0]  bit_q, bit_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           hit_q, hit_d;

    logic [NREQ-1:0] gnt_s;
    logic [IDW-1:0]  gnt_idx_s;
    logic            arb_en_s;
    logic [W-1:0]    sel_word_s;

    // Grants are suppressed during reset so no acceptance pulse leaks out
    assign arb_en_s = (state_q == ST_IDLE) && !rst;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req_i (sched.req_valid),
        .ptr_i (ptr_q),
        .en_i  (arb_en_s),
        .gnt_o (gnt_s),
        .idx_o (gnt_idx_s)
    );

    // Word of the granted requester
    always_comb begin
        sel_word_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_s[i]) begin
                sel_word_s = sched.req_data[i*W +: W];
            end else begin
                sel_word_s = sel_word_s;
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            shreg_q <= '0;
            bit_q   <= '0;
            cnt_q   <= '0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
            hit_q   <= hit_d;
        end
    end

    // Next-state logic; det_y is only counted while a word is being shifted
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q;
        hit_d   = hit_q;
        case (state_q)
            ST_IDLE: begin
                if (|gnt_s) begin
                    shreg_d = sel_word_s;
                    id_d    = gnt_idx_s;
                    ptr_d   = (gnt_idx_s == IDW'(NREQ - 1)) ? '0 : gnt_idx_s + IDW'(1);
                    state_d = ST_CLEAR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                bit_d   = '0;
                cnt_d   = '0;
                hit_d   = 1'b0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                shreg_d = {shreg_q[W-2:0], 1'b0};
                bit_d   = bit_q + CW'(1);
                if (det_y) begin
                    cnt_d = cnt_q + CW'(1);
                    hit_d = 1'b1;
                end else begin
                    cnt_d = cnt_q;
                    hit_d = hit_q;
                end
                if (bit_q == CW'(W - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (sched.resp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign sched.req_ready  = gnt_s;
    assign sched.resp_valid = (state_q == ST_DONE);
    assign sched.resp_id    = id_q;
    assign sched.resp_count = cnt_q;
    assign sched.resp_hit   = hit_q;
    assign det_rst          = rst || (state_q == ST_CLEAR);
    assign det_din          = (state_q == ST_SHIFT) ? shreg_q[W-1] : 1'b0;
    assign busy             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Directed bench for seq_det_scheduler with a behavioural 1101 Mealy detector
// and a response scoreboard drained by an independent monitor.
module tb_seq_det_scheduler;
    import seq_det_pkg::*;

    localparam int NREQ = 4;
    localparam int W    = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic det_rst, det_din, det_y, busy;

    seq_det_scheduler_if #(.NREQ(NREQ), .W(W)) bus ();

    seq_det_scheduler #(.NREQ(NREQ), .W(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .sched   (bus),
        .det_rst (det_rst),
        .det_din (det_din),
        .det_y   (det_y),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // External detector: last three bits seen plus the current input
    logic [2:0] dh_q;
    always_ff @(posedge clk) begin
        if (det_rst) dh_q <= 3'b000;
        else         dh_q <= {dh_q[1:0], det_din};
    end
    assign det_y = ({dh_q, det_din} == DET_PATTERN);

    typedef struct {
        int id;
        int cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_resp(input int id, input int cnt);
        exp_t e;
        e.id  = id;
        e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    task automatic wait_grant(input int g);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (bus.req_ready != '0) seen = 1'b1;
        end
        check($sformatf("grant_seen_%0d", g), int'(seen), 1);
        check($sformatf("grant_onehot_%0d", g), int'(bus.req_ready), 1 << g);
    endtask

    task automatic run_word(input int idx, input logic [W-1:0] word, input int cnt);
        expect_resp(idx, cnt);
        @(posedge clk); #1;
        bus.req_valid[idx]         = 1'b1;
        bus.req_data[idx*W +: W]   = word;
        wait_grant(idx);
        check("det_rst_accept", int'(det_rst), 0);
        @(posedge clk); #1;
        bus.req_valid[idx] = 1'b0;
        @(negedge clk);
        check("clear_det_rst", int'(det_rst), 1);
        check("clear_det_din", int'(det_din), 0);
        check("clear_busy", int'(busy), 1);
        for (int b = 0; b < W; b++) begin
            @(negedge clk);
            check($sformatf("din_bit%0d", b), int'(det_din), int'(word[W-1-b]));
            check("shift_det_rst", int'(det_rst), 0);
        end
        @(negedge clk);
        check("resp_valid_latency", int'(bus.resp_valid), 1);
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && exp_q.size() != 0; k++) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic quiet;
        bus.req_valid  = '0;
        bus.req_data   = '0;
        bus.resp_ready = 1'b1;

        // Monitor: every accepted response must match the head of the scoreboard
        fork
            forever begin : monitor
                exp_t e;
                @(negedge clk);
                if (!rst && bus.resp_valid && bus.resp_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_resp: got id %0d count %0d, expected no response",
                                 bus.resp_id, bus.resp_count);
                    end else begin
                        e = exp_q.pop_front();
                        check("resp_id", int'(bus.resp_id), e.id);
                        check("resp_count", int'(bus.resp_count), e.cnt);
                        check("resp_hit", int'(bus.resp_hit), (e.cnt != 0) ? 1 : 0);
                    end
                end
            end
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_det_rst", int'(det_rst), 1);
        check("rst_req_ready", int'(bus.req_ready), 0);
        check("rst_resp_valid", int'(bus.resp_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_det_din", int'(det_din), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_det_rst", int'(det_rst), 0);
        check("idle_busy", int'(busy), 0);
        check("idle_resp_id", int'(bus.resp_id), 0);
        check("idle_resp_count", int'(bus.resp_count), 0);
        check("idle_resp_hit", int'(bus.resp_hit), 0);

        // Basic match, all-ones/all-zeros, and word isolation
        run_word(0, 8'b1101_1010, 2);
        run_word(1, 8'hFF, 0);
        run_word(1, 8'h00, 0);
        run_word(2, 8'b0000_0110, 0);
        run_word(2, 8'b1000_0000, 0);

        // Backpressure in DONE with a competing request pending
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        run_word(3, 8'b0110_1101, 2);
        @(posedge clk); #1;
        bus.req_valid[0]     = 1'b1;
        bus.req_data[0 +: W] = 8'h00;
        expect_resp(0, 0);
        repeat (5) begin
            @(negedge clk);
            check("bp_resp_valid", int'(bus.resp_valid), 1);
            check("bp_resp_count", int'(bus.resp_count), 2);
            check("bp_resp_id", int'(bus.resp_id), 3);
            check("bp_req_ready", int'(bus.req_ready), 0);
        end
        @(posedge clk); #1;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_back_idle", int'(bus.resp_valid), 0);
        check("bp_grant_in_idle", int'(bus.req_ready), 1);
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b0;
        drain();

        // Round-robin with all requesters held valid from reset
        @(posedge clk); #1;
        rst           = 1'b1;
        bus.req_valid = 4'hF;
        bus.req_data  = {8'b1101_1011, 8'h00, 8'b1101_0000, 8'b1101_1010};
        expect_resp(0, 2);
        expect_resp(1, 1);
        expect_resp(2, 0);
        expect_resp(3, 2);
        expect_resp(0, 2);
        expect_resp(2, 0);
        @(negedge clk);
        check("rr_rst_req_ready", int'(bus.req_ready), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        wait_grant(0);
        wait_grant(1);
        wait_grant(2);
        wait_grant(3);
        @(posedge clk); #1;
        bus.req_valid = 4'b0101;
        wait_grant(0);
        wait_grant(2);
        @(posedge clk); #1;
        bus.req_valid = '0;
        drain();

        // Reset during the 4th SHIFT cycle drops the word and the pointer
        @(posedge clk); #1;
        bus.req_valid[1]     = 1'b1;
        bus.req_data[W +: W] = 8'b1101_1010;
        wait_grant(1);
        @(posedge clk); #1;
        bus.req_valid[1] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_det_rst", int'(det_rst), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", int'(busy), 0);
        check("midrst_resp_valid", int'(bus.resp_valid), 0);
        check("midrst_resp_id", int'(bus.resp_id), 0);
        check("midrst_resp_count", int'(bus.resp_count), 0);
        check("midrst_resp_hit", int'(bus.resp_hit), 0);
        check("midrst_det_din", int'(det_din), 0);
        check("midrst_det_rst_low", int'(det_rst), 0);
        check("midrst_req_ready", int'(bus.req_ready), 0);
        quiet = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (bus.resp_valid || busy) quiet = 1'b0;
        end
        check("midrst_no_response", int'(quiet), 1);
        expect_resp(0, 2);
        expect_resp(2, 0);
        @(posedge clk); #1;
        bus.req_data[0 +: W]   = 8'b1101_1010;
        bus.req_data[2*W +: W] = 8'h00;
        bus.req_valid          = 4'b0101;
        wait_grant(0);
        wait_grant(2);
        @(posedge clk); #1;
        bus.req_valid = '0;
        drain();

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
